pwf_scan_ctrl: RTL and testbench
================================

Name: pwf_scan_ctrl

Overview:
- Multi-channel pulse-width filter scheduler. One shared filter datapath (synchronizer sample, counter compare, threshold) is time-multiplexed over CH_N raw inputs in a fixed round-robin scan.
- Each channel's filtered output c[i] asserts after HI_CNT consecutive high samples at that channel's scan slots. It clears on the first low sample.
- Filtered-edge events are queued in a small FIFO with a valid/ready interface toward the downstream consumer.

Parameters:
- CH_N, 4, number of input channels (2..16); CH_W = max(1,$clog2(CH_N)).
- HI_CNT, 13, consecutive high slot samples required to assert c[i] (2..255); CNT_W = $clog2(HI_CNT+1).
- EVT_DEPTH, 4, event FIFO depth (power of 2, >=2).

Ports:
- clk4m  in  1  4 MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scan enable
- a  in  CH_N  raw asynchronous channel inputs
- c  out  CH_N  filtered channel levels
- scan_ch  out  CH_W  channel serviced this cycle
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_ch  out  CH_W  channel of head event
- evt_edge  out  1  1 = rising, 0 = falling
- ovf  out  1  sticky event-drop flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst_n=0): c=0, all counters=0, scan_ch=0, FIFO empty (evt_valid=0, evt_ch=0, evt_edge=0), ovf=0, synchronizers=0.
- Input path: a[i] passes a 2-FF synchronizer to a_s[i] in every channel. Only a_s is used by the filter.
- Scan:
  - While en=1, scan_ch increments by 1 per cycle and wraps CH_N-1 -> 0.
  - Channel i is serviced exactly once every CH_N cycles.
  - Only channel scan_ch is updated per cycle; all other channels hold.
- Per-slot update for channel k = scan_ch:
  - a_s[k]=1 and c[k]=0: cnt[k]+1. If the result equals HI_CNT, then on that same edge c[k]<=1, cnt[k]<=0, and a rising event {k,1} is pushed.
  - a_s[k]=1 and c[k]=1: hold.
  - a_s[k]=0: cnt[k]<=0. If c[k]=1, then c[k]<=0 and a falling event {k,0} is pushed (push only with the feature enabled).
- Latency: c[k] rises on the HI_CNT-th consecutive serviced slot with a_s[k]=1. The event is visible on evt_valid/evt_ch the cycle after that edge.
- en=0:
  - On the next edge, all cnt and c clear to 0 and scan_ch clears to 0; no events are generated by this clearing.
  - Synchronizers keep running. FIFO contents and ovf are retained, and popping continues.
- FIFO:
  - At most one push per cycle, since only one channel is serviced.
  - Pop occurs when evt_valid & evt_ready.
  - Push to a full FIFO is dropped and sets ovf, except when a pop happens in the same cycle; then push and pop both complete and ovf is unchanged.
  - Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged, order preserved (FIFO order).
  - Pop when empty: no effect.
  - evt_ch/evt_edge hold their value while evt_valid=1 and evt_ready=0.
- ovf: set by a drop, cleared by ovf_clr. A drop and ovf_clr in the same cycle leave ovf=1 (set wins).
- Counter width: cnt never exceeds HI_CNT-1 at rest, so no wrap is possible.

Optional Feature:
- Macro: PWF_FALL_EVT_EN.
- Defined: falling edges of c[k] push {k,0} events under the same FIFO/overflow rules as rising events.
- Undefined: no falling events; evt_edge is driven constant 1 and all FIFO entries are rising events.

Test Plan (CH_N=4, HI_CNT=13, EVT_DEPTH=4):
- Hold a[0]=1 from reset release, en=1, evt_ready=1:
  - c[0]=0 after 12 serviced slots of ch0 with a_s[0]=1, and c[0]=1 after the 13th.
  - One event: evt_ch=0, evt_edge=1, evt_valid high for exactly 1 cycle.
- a[1] high for 10 ch1 slots then low: c[1] stays 0 and no event. Raising a[1] again restarts the count from 0, so it needs 13 further slots.
- With c[2]=1, drive a[2]=0: c[2] clears at the next ch2 slot.
  - PWF_FALL_EVT_EN defined: event {2,0}.
  - Undefined: no event.
- evt_ready=0, all a=1:
  - Four rising events are queued in order ch0, ch1, ch2, ch3.
  - Toggle a[0] low then high for 13 slots: the 5th event is dropped and ovf=1.
  - ovf_clr pulse returns ovf to 0; FIFO still holds 4 entries.
- Full FIFO plus a new rising event in the same cycle as evt_ready=1: the head pops, the new event is appended, and ovf stays 0.
- Deassert en with c=4'b1111 and counters mid-count: the next edge gives c=0 and scan_ch=0, queued events are retained, and no new event is produced.
- Assert rst_n=0 mid-count: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/pwf_scan_ctrl_if.sv
// Event handshake bundle between pwf_scan_ctrl (master) and its consumer (slave).
// Carries the head-of-FIFO filtered-edge event: channel number and edge direction.
`timescale 1ns/1ps
interface pwf_scan_ctrl_if #(
  parameter int CH_N = 4
);
  localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1;

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_edge;

  modport master (output evt_valid, output evt_ch, output evt_edge, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_ch, input  evt_edge, output evt_ready);
endinterface

// File: rtl/pwf_scan_ctrl.sv
// Multi-channel pulse-width filter scheduler.
// A single filter datapath is shared round-robin over CH_N synchronized inputs;
// each channel asserts c_o[k] after HI_CNT consecutive high samples at its own
// scan slots and clears on the first low sample. Filtered edges are queued in a
// small event FIFO presented through pwf_scan_ctrl_if.
// Build option: define PWF_FALL_EVT_EN to also queue falling-edge events;
// without it only rising events exist and evt_edge is tied to 1.
`timescale 1ns/1ps
module pwf_scan_ctrl #(
  parameter int CH_N      = 4,
  parameter int HI_CNT    = 13,
  parameter int EVT_DEPTH = 4,
  localparam int CH_W     = (CH_N > 1) ? $clog2(CH_N) : 1,
  localparam int CNT_W    = $clog2(HI_CNT + 1)
) (
  input  logic            clk4m,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [CH_N-1:0] a_i,
  output logic [CH_N-1:0] c_o,
  output logic [CH_W-1:0] scan_ch_o,
  pwf_scan_ctrl_if.master evt_if,
  output logic            ovf_o,
  input  logic            ovf_clr_i
);

  localparam int AW = $clog2(EVT_DEPTH);
`ifdef PWF_FALL_EVT_EN
  localparam int EW = CH_W + 1;   // {channel, edge}
`else
  localparam int EW = CH_W;       // channel only; every entry is a rising edge
`endif

  // Input synchronizers
  logic [CH_N-1:0] sync1_q;
  logic [CH_N-1:0] a_s_q;

  // Filter state
  logic [CH_N-1:0]  c_q, c_d;
  logic [CNT_W-1:0] cnt_q [CH_N];
  logic [CNT_W-1:0] cnt_d [CH_N];
  logic [CH_W-1:0]  scan_q, scan_d;

  // Event generation for the serviced channel
  logic          push;
  logic [EW-1:0] push_ent;
`ifdef PWF_FALL_EVT_EN
  logic          push_edge;
`endif

  // Event FIFO
  logic [EW-1:0] mem_q [EVT_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          ovf_q;

  // Two-stage synchronizer on every raw input; runs regardless of en_i.
  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      a_s_q   <= '0;
    end else begin
      sync1_q <= a_i;
      a_s_q   <= sync1_q;
    end
  end

  // Shared filter datapath: update only the channel addressed by scan_q.
  always_comb begin
    c_d    = c_q;
    cnt_d  = cnt_q;
    scan_d = scan_q;
    push   = 1'b0;
`ifdef PWF_FALL_EVT_EN
    push_edge = 1'b1;
`endif
    if (!en_i) begin
      // Disabling flushes the filter silently; no events for these clears.
      c_d    = '0;
      scan_d = '0;
      for (int i = 0; i < CH_N; i++) cnt_d[i] = '0;
    end else begin
      scan_d = (scan_q == CH_W'(CH_N - 1)) ? '0 : scan_q + 1'b1;
      if (a_s_q[scan_q]) begin
        if (!c_q[scan_q]) begin
          if (cnt_q[scan_q] == CNT_W'(HI_CNT - 1)) begin
            c_d[scan_q]   = 1'b1;
            cnt_d[scan_q] = '0;
            push          = 1'b1;
          end else begin
            cnt_d[scan_q] = cnt_q[scan_q] + 1'b1;
          end
        end
      end else begin
        cnt_d[scan_q] = '0;
        if (c_q[scan_q]) begin
          c_d[scan_q] = 1'b0;
`ifdef PWF_FALL_EVT_EN
          push      = 1'b1;
          push_edge = 1'b0;
`endif
        end
      end
    end
  end

`ifdef PWF_FALL_EVT_EN
  assign push_ent = {scan_q, push_edge};
`else
  assign push_ent = scan_q;
`endif

  // Filter state registers.
  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      scan_q <= '0;
      for (int i = 0; i < CH_N; i++) cnt_q[i] <= '0;
    end else begin
      c_q    <= c_d;
      scan_q <= scan_d;
      for (int i = 0; i < CH_N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign fifo_full = (count_q == (AW+1)'(EVT_DEPTH));
  assign pop       = (count_q != '0) && evt_if.evt_ready;
  assign push_ok   = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  // Event FIFO storage and pointers.
  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < EVT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_ent;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Sticky overflow flag; a drop outranks a simultaneous clear.
  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign c_o              = c_q;
  assign scan_ch_o        = scan_q;
  assign ovf_o            = ovf_q;
  assign evt_if.evt_valid = (count_q != '0);
`ifdef PWF_FALL_EVT_EN
  assign evt_if.evt_ch    = mem_q[rd_q][EW-1:1];
  assign evt_if.evt_edge  = mem_q[rd_q][0];
`else
  assign evt_if.evt_ch    = mem_q[rd_q];
  assign evt_if.evt_edge  = 1'b1;
`endif

endmodule

// File: tb/tb_pwf_scan_ctrl.sv
// Directed bench for pwf_scan_ctrl (CH_N=4, HI_CNT=13, EVT_DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
`timescale 1ns/1ps
module tb_pwf_scan_ctrl;

`ifdef PWF_FALL_EVT_EN
  localparam bit FALL = 1'b1;
`else
  localparam bit FALL = 1'b0;
`endif

  logic       clk4m;
  logic       rst_n;
  logic       en;
  logic [3:0] a;
  logic [3:0] c;
  logic [1:0] scan_ch;
  logic       ovf;
  logic       ovf_clr;

  int n_checks;
  int n_pass;

  pwf_scan_ctrl_if #(.CH_N(4)) evt_if ();

  pwf_scan_ctrl #(.CH_N(4), .HI_CNT(13), .EVT_DEPTH(4)) dut (
    .clk4m     (clk4m),
    .rst_n     (rst_n),
    .en_i      (en),
    .a_i       (a),
    .c_o       (c),
    .scan_ch_o (scan_ch),
    .evt_if    (evt_if.master),
    .ovf_o     (ovf),
    .ovf_clr_i (ovf_clr)
  );

  initial clk4m = 1'b0;
  always #125 clk4m = ~clk4m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk4m);
    #1;
  endtask

  // Advance until channel k has been serviced n more times (bounded).
  task automatic run_slots(input int k, input int n);
    int got = 0;
    int it  = 0;
    while (got < n && it < n * 4 + 8) begin
      if (scan_ch == 2'(k)) begin
        tick();
        got++;
      end else begin
        tick();
      end
      it++;
    end
    if (got != n) chk("slot_budget", got, n);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    a        = 4'b0000;
    ovf_clr  = 1'b0;
    evt_if.evt_ready = 1'b0;

    // Reset state
    #300;
    chk("rst_c",     c, 0);
    chk("rst_scan",  scan_ch, 0);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_ch",    evt_if.evt_ch, 0);
    chk("rst_edge",  evt_if.evt_edge, FALL ? 0 : 1);
    chk("rst_ovf",   ovf, 0);

    // Test 1: a[0] high, 12 slots keep c0 low, 13th raises it
    a = 4'b0001;
    evt_if.evt_ready = 1'b1;
    @(negedge clk4m);
    rst_n = 1'b1;
    tick(); tick(); tick();
    en = 1'b1;
    run_slots(0, 12);
    chk("t1_c0_12",    c[0], 0);
    chk("t1_novalid",  evt_if.evt_valid, 0);
    run_slots(0, 1);
    chk("t1_c0_13",    c[0], 1);
    chk("t1_valid",    evt_if.evt_valid, 1);
    chk("t1_ch",       evt_if.evt_ch, 0);
    chk("t1_edge",     evt_if.evt_edge, 1);
    tick();
    chk("t1_valid1cy", evt_if.evt_valid, 0);

    // Test 2: a[1] high 10 slots then low; restart needs 13 more
    run_slots(1, 1);
    a[1] = 1'b1;
    run_slots(1, 10);
    chk("t2_c1_10",    c[1], 0);
    a[1] = 1'b0;
    run_slots(1, 1);
    chk("t2_c1_low",   c[1], 0);
    chk("t2_noevt",    evt_if.evt_valid, 0);
    a[1] = 1'b1;
    run_slots(1, 12);
    chk("t2_c1_12",    c[1], 0);
    run_slots(1, 1);
    chk("t2_c1_13",    c[1], 1);
    chk("t2_valid",    evt_if.evt_valid, 1);
    chk("t2_ch",       evt_if.evt_ch, 1);
    tick();
    chk("t2_pop",      evt_if.evt_valid, 0);

    // Test 3: ch2 rises, then falls
    a[2] = 1'b1;
    run_slots(2, 12);
    chk("t3_c2_12",    c[2], 0);
    run_slots(2, 1);
    chk("t3_c2_13",    c[2], 1);
    chk("t3_valid",    evt_if.evt_valid, 1);
    chk("t3_ch",       evt_if.evt_ch, 2);
    tick();
    a[2] = 1'b0;
    run_slots(2, 1);
    chk("t3_c2_fall",  c[2], 0);
    chk("t3_fvalid",   evt_if.evt_valid, FALL);
    if (FALL) begin
      chk("t3_fch",    evt_if.evt_ch, 2);
      chk("t3_fedge",  evt_if.evt_edge, 0);
    end
    tick();

    // Test 4: fill FIFO, then overflow on a fifth event
    evt_if.evt_ready = 1'b0;
    a  = 4'b1111;
    en = 1'b0;
    tick(); tick(); tick();
    chk("t4_clr_c",    c, 0);
    chk("t4_clr_evt",  evt_if.evt_valid, 0);
    en = 1'b1;
    run_slots(3, 13);
    chk("t4_c_all",    c, 4'b1111);
    chk("t4_valid",    evt_if.evt_valid, 1);
    chk("t4_head",     evt_if.evt_ch, 0);
    chk("t4_ovf0",     ovf, 0);
    run_slots(0, 1);
    a[0] = 1'b0;
    run_slots(0, 1);
    chk("t4_c0_fall",  c, 4'b1110);
    chk("t4_ovf_fall", ovf, FALL);
    a[0] = 1'b1;
    run_slots(0, 13);
    chk("t4_c0_rise",  c[0], 1);
    chk("t4_ovf",      ovf, 1);
    chk("t4_head_hold", evt_if.evt_ch, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr",  ovf, 0);
    chk("t4_still",    evt_if.evt_valid, 1);

    // Test 5: full FIFO, new rising event in the same cycle as a pop
    run_slots(1, 1);
    a[1] = 1'b0;
    run_slots(1, 1);
    chk("t5_c1_low",   c[1], 0);
    a[1]    = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_ovf_clr",  ovf, 0);
    run_slots(1, 12);
    chk("t5_c1_12",    c[1], 0);
    tick(); tick(); tick();
    chk("t5_scan",     scan_ch, 1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    chk("t5_c1",       c[1], 1);
    chk("t5_ovf",      ovf, 0);
    chk("t5_head",     evt_if.evt_ch, 1);

    // Test 6: en low flushes filter, keeps FIFO; drain checks order
    chk("t6_c_pre",    c, 4'b1111);
    en = 1'b0;
    tick();
    chk("t6_c",        c, 0);
    chk("t6_scan",     scan_ch, 0);
    tick();
    chk("t6_scan_hold", scan_ch, 0);
    evt_if.evt_ready = 1'b1;
    begin
      logic [1:0] exp_q [4];
      exp_q[0] = 2'd1; exp_q[1] = 2'd2; exp_q[2] = 2'd3; exp_q[3] = 2'd1;
      for (int i = 0; i < 4; i++) begin
        chk("t6_dvalid", evt_if.evt_valid, 1);
        chk("t6_dch",    evt_if.evt_ch, exp_q[i]);
        chk("t6_dedge",  evt_if.evt_edge, 1);
        tick();
      end
    end
    chk("t6_empty",    evt_if.evt_valid, 0);

    // Test 7: asynchronous reset mid-operation
    evt_if.evt_ready = 1'b0;
    en = 1'b1;
    run_slots(3, 13);
    tick();
    chk("t7_pre_c",    c, 4'b1111);
    chk("t7_pre_scan", scan_ch, 1);
    chk("t7_pre_val",  evt_if.evt_valid, 1);
    #20;
    rst_n = 1'b0;
    #20;
    chk("t7_c",        c, 0);
    chk("t7_scan",     scan_ch, 0);
    chk("t7_valid",    evt_if.evt_valid, 0);
    chk("t7_ch",       evt_if.evt_ch, 0);
    chk("t7_ovf",      ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
